// File: rtl/jam_param_if.sv
// ---------------------------------------------------------------------------
// jam_param_if
// Bundles the run handshake, the cost-ROM address/data pair and the result
// outputs of the jam_param job-assignment solver.
//   start      : run request toward the solver
//   busy       : solver run in progress (through the Valid cycle)
//   W, J       : worker / job index presented to the cost ROM
//   Cost       : ROM data for the (W, J) pair of the previous cycle
//   MinCost    : minimum total cost found
//   MatchCount : number of permutations reaching MinCost (saturating)
//   BestJ      : first optimal assignment, BestJ[LW*w +: LW] = job of worker w
//   Valid      : one-cycle completion pulse
// Modports: master = requester / ROM side, slave = solver side.
// ---------------------------------------------------------------------------
interface jam_param_if #(
  parameter int N      = 8,
  parameter int COST_W = 7,
  parameter int MC_W   = 4
);
  localparam int LW    = $clog2(N);
  localparam int SUM_W = COST_W + LW;

  logic                start;
  logic                busy;
  logic [LW-1:0]       W;
  logic [LW-1:0]       J;
  logic [COST_W-1:0]   Cost;
  logic [SUM_W-1:0]    MinCost;
  logic [MC_W-1:0]     MatchCount;
  logic [N*LW-1:0]     BestJ;
  logic                Valid;

  modport master (
    output start, Cost,
    input  busy, W, J, MinCost, MatchCount, BestJ, Valid
  );

  modport slave (
    input  start, Cost,
    output busy, W, J, MinCost, MatchCount, BestJ, Valid
  );
endinterface

// File: rtl/jam_param.sv
// ---------------------------------------------------------------------------
// jam_param
// Exhaustive N x N job-assignment solver. Walks all N! permutations in
// lexicographic order, fetching one cost entry per cycle from an external
// ROM with one cycle of read latency, and keeps the minimum total cost, how
// many permutations reach it (saturating) and the first optimal assignment.
// Ports:
//   CLK : clock, rising edge
//   RST : asynchronous active-high reset
//   bus : jam_param_if slave modport (handshake, ROM port, results)
// Each permutation costs N FETCH cycles plus one EVAL cycle.
// ---------------------------------------------------------------------------
module jam_param #(
  parameter int N      = 8,
  parameter int COST_W = 7,
  parameter int MC_W   = 4
) (
  input  logic       CLK,
  input  logic       RST,
  jam_param_if.slave bus
);
  localparam int LW    = $clog2(N);
  localparam int SUM_W = COST_W + LW;
  localparam int PW    = N * LW;

  typedef enum logic [1:0] {IDLE, FETCH, EVAL} state_t;

  state_t            state, state_nxt;
  logic [LW-1:0]     k, k_nxt;
  logic [PW-1:0]     perm, perm_nxt;
  logic [PW-1:0]     perm_first, perm_succ;
  logic              perm_last;
  logic [SUM_W-1:0]  acc, acc_nxt, sum_final;
  logic [SUM_W-1:0]  min_cost, min_nxt;
  logic [MC_W-1:0]   match, match_nxt;
  logic [PW-1:0]     best, best_nxt;
  logic              busy_r, busy_nxt;
  logic              valid_r, valid_nxt;
  logic [LW-1:0]     w_r, w_nxt, j_r, j_nxt;

  int                piv, sel;
  logic [LW-1:0]     piv_val, sel_val;
  logic [LW-1:0]     swapped [N];

  // Identity permutation loaded at the start of every run
  always_comb begin
    perm_first = '0;
    for (int m = 0; m < N; m++) perm_first[LW*m +: LW] = LW'(m);
  end

  // Lexicographic successor of perm. All element selects use constant
  // indices compared against piv/sel so the logic stays a plain mux tree.
  // perm_last is set when no ascending pair exists (fully descending).
  always_comb begin
    piv       = 0;
    sel       = 0;
    perm_last = 1'b1;
    piv_val   = '0;
    sel_val   = '0;
    perm_succ = perm;
    for (int i = 0; i < N - 1; i++) begin
      if (perm[LW*i +: LW] < perm[LW*(i+1) +: LW]) begin
        piv       = i;
        perm_last = 1'b0;
      end
    end
    for (int m = 0; m < N; m++)
      if (m == piv) piv_val = perm[LW*m +: LW];
    for (int m = 0; m < N; m++)
      if (m > piv && perm[LW*m +: LW] > piv_val) sel = m;
    for (int m = 0; m < N; m++)
      if (m == sel) sel_val = perm[LW*m +: LW];
    for (int m = 0; m < N; m++) begin
      if (m == piv)      swapped[m] = sel_val;
      else if (m == sel) swapped[m] = piv_val;
      else               swapped[m] = perm[LW*m +: LW];
    end
    // Suffix after the pivot is reversed: position m takes N+piv-m
    for (int m = 0; m < N; m++) begin
      if (m <= piv) perm_succ[LW*m +: LW] = swapped[m];
      else begin
        for (int s = 0; s < N; s++)
          if (s == N + piv - m) perm_succ[LW*m +: LW] = swapped[s];
      end
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath updates. W/J are computed one cycle ahead so the
  // registered ROM address lines up with the FETCH cycle it belongs to.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    perm_nxt  = perm;
    acc_nxt   = acc;
    min_nxt   = min_cost;
    match_nxt = match;
    best_nxt  = best;
    busy_nxt  = busy_r;
    valid_nxt = 1'b0;
    w_nxt     = '0;
    j_nxt     = '0;
    sum_final = acc + SUM_W'(bus.Cost);
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (bus.start) begin
          state_nxt = FETCH;
          k_nxt     = '0;
          perm_nxt  = perm_first;
          acc_nxt   = '0;
          min_nxt   = '1;
          match_nxt = '0;
          best_nxt  = '0;
          busy_nxt  = 1'b1;
        end
      end
      FETCH: begin
        // Cost seen in FETCH k belongs to worker k-1; k==0 sees a stale word
        acc_nxt = (k == '0) ? '0 : sum_final;
        if (int'(k) == N - 1) begin
          state_nxt = EVAL;
        end else begin
          k_nxt = k + LW'(1);
          w_nxt = k + LW'(1);
          for (int m = 0; m < N; m++)
            if (m == int'(k) + 1) j_nxt = perm[LW*m +: LW];
        end
      end
      EVAL: begin
        // Strictly-smaller update keeps the lexicographically first optimum
        if (sum_final < min_cost) begin
          min_nxt   = sum_final;
          match_nxt = MC_W'(1);
          best_nxt  = perm;
        end else if (sum_final == min_cost && match != '1) begin
          match_nxt = match + MC_W'(1);
        end
        if (perm_last) begin
          state_nxt = IDLE;
          valid_nxt = 1'b1;
        end else begin
          state_nxt = FETCH;
          perm_nxt  = perm_succ;
          k_nxt     = '0;
          j_nxt     = perm_succ[LW-1:0];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      k        <= '0;
      perm     <= '0;
      acc      <= '0;
      min_cost <= '1;
      match    <= '0;
      best     <= '0;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      w_r      <= '0;
      j_r      <= '0;
    end else begin
      k        <= k_nxt;
      perm     <= perm_nxt;
      acc      <= acc_nxt;
      min_cost <= min_nxt;
      match    <= match_nxt;
      best     <= best_nxt;
      busy_r   <= busy_nxt;
      valid_r  <= valid_nxt;
      w_r      <= w_nxt;
      j_r      <= j_nxt;
    end
  end

  assign bus.busy       = busy_r;
  assign bus.Valid      = valid_r;
  assign bus.W          = w_r;
  assign bus.J          = j_r;
  assign bus.MinCost    = min_cost;
  assign bus.MatchCount = match;
  assign bus.BestJ      = best;

endmodule

// File: tb/tb_jam_param.sv
// ---------------------------------------------------------------------------
// tb_jam_param
// Drives four jam_param instances (N = 3, 4, 6, 8) sharing one clock, each
// with its own reset, start and cost-ROM contents. A per-instance model
// enumerates permutations in software, brute-forces the expected results and
// checks busy/Valid/W/J/results every cycle; the main sequence adds literal
// expectations taken from hand-worked matrices.
// ---------------------------------------------------------------------------
module tb_jam_param;
  logic       CLK = 1'b0;
  logic [3:0] rstV;
  logic [3:0] startV;
  logic [3:0] validV;
  logic [3:0] busyV;
  int         costM [4][8][8];
  int         checkCount = 0;
  int         passCount  = 0;

  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports mismatches
  function automatic void checkOutput(string name, int got, int exp);
    checkCount++;
    if (got == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
  endfunction

  // Software lexicographic successor; returns 0 when a was the last one
  function automatic bit nextPerm(inout int a[8], input int n);
    int i, j, t;
    i = n - 2;
    while (i >= 0 && a[i] >= a[i+1]) i--;
    if (i < 0) return 1'b0;
    j = n - 1;
    while (a[j] <= a[i]) j--;
    t = a[i]; a[i] = a[j]; a[j] = t;
    for (int lo = i + 1, hi = n - 1; lo < hi; lo++, hi--) begin
      t = a[lo]; a[lo] = a[hi]; a[hi] = t;
    end
    return 1'b1;
  endfunction

  // Brute force over all permutations of costM[g]
  function automatic void bruteForce(input int g, input int n, input int lw,
                                     output int mn, output int cnt, output int best);
    int a[8];
    int s;
    for (int i = 0; i < 8; i++) a[i] = i;
    mn = 1 << 30; cnt = 0; best = 0;
    do begin
      s = 0;
      for (int w = 0; w < n; w++) s += costM[g][w][a[w]];
      if (s < mn) begin
        mn = s; cnt = 1; best = 0;
        for (int w = 0; w < n; w++) best |= a[w] << (lw * w);
      end else if (s == mn) cnt++;
    end while (nextPerm(a, n));
  endfunction

  for (genvar g = 0; g < 4; g++) begin : inst
    localparam int NG   = (g == 0) ? 3 : (g == 1) ? 4 : (g == 2) ? 6 : 8;
    localparam int LWG  = $clog2(NG);
    localparam int SUMG = 7 + LWG;

    jam_param_if #(.N(NG), .COST_W(7), .MC_W(4)) bus ();
    jam_param #(.N(NG), .COST_W(7), .MC_W(4)) dut (
      .CLK (CLK),
      .RST (rstV[g]),
      .bus (bus)
    );

    assign bus.start = startV[g];
    assign validV[g] = bus.Valid;
    assign busyV[g]  = bus.busy;

    // Cost ROM: one cycle of read latency
    always @(posedge CLK) bus.Cost <= 7'(costM[g][int'(bus.W)][int'(bus.J)]);

    int p[8];
    int mT = 0, total = 1, pos = 0;
    bit mRun = 1'b0, mValid = 1'b0, mKnown = 1'b0;
    int eMin = 0, eMc = 0, eBest = 0, fMin = 0, fMc = 0, fBest = 0;

    // Behavioural model: run timeline and expected results
    initial begin
      for (int i = 2; i <= NG; i++) total *= i;
      total *= NG + 1;
      forever begin
        @(posedge CLK or posedge rstV[g]);
        if (rstV[g]) begin
          mRun = 1'b0; mValid = 1'b0; mKnown = 1'b1;
          eMin = (1 << SUMG) - 1; eMc = 0; eBest = 0;
        end else if (!mRun) begin
          mValid = 1'b0;
          if (startV[g]) begin
            mRun = 1'b1; mT = 0; mKnown = 1'b0;
            for (int i = 0; i < 8; i++) p[i] = i;
            bruteForce(g, NG, LWG, fMin, fMc, fBest);
          end
        end else begin
          mT++;
          if (mT == total) begin
            mRun = 1'b0; mValid = 1'b1; mKnown = 1'b1;
            eMin = fMin; eMc = (fMc > 15) ? 15 : fMc; eBest = fBest;
          end else if (mT % (NG + 1) == 0) begin
            void'(nextPerm(p, NG));
          end
        end
      end
    end

    // Compare process, away from the active edge
    initial forever begin
      @(negedge CLK);
      checkOutput($sformatf("N%0d busy", NG), int'(bus.busy), int'(mRun || mValid));
      checkOutput($sformatf("N%0d Valid", NG), int'(bus.Valid), int'(mValid));
      pos = mT % (NG + 1);
      if (mRun && pos < NG) begin
        checkOutput($sformatf("N%0d W t=%0d", NG, mT), int'(bus.W), pos);
        checkOutput($sformatf("N%0d J t=%0d", NG, mT), int'(bus.J), p[pos]);
      end else if (!mRun) begin
        checkOutput($sformatf("N%0d idle W", NG), int'(bus.W), 0);
        checkOutput($sformatf("N%0d idle J", NG), int'(bus.J), 0);
      end
      if (mKnown) begin
        checkOutput($sformatf("N%0d MinCost", NG), int'(bus.MinCost), eMin);
        checkOutput($sformatf("N%0d MatchCount", NG), int'(bus.MatchCount), eMc);
        checkOutput($sformatf("N%0d BestJ", NG), int'(bus.BestJ), eBest);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  function automatic bit validOf(input int g);
    case (g)
      0: return validV[0];
      1: return validV[1];
      2: return validV[2];
      default: return validV[3];
    endcase
  endfunction

  function automatic bit busyOf(input int g);
    case (g)
      0: return busyV[0];
      1: return busyV[1];
      2: return busyV[2];
      default: return busyV[3];
    endcase
  endfunction

  // One-cycle start pulse; returns in cycle 0 of the run
  task automatic applyStimulus(input int g);
    case (g)
      0: startV[0] = 1'b1;
      1: startV[1] = 1'b1;
      2: startV[2] = 1'b1;
      default: startV[3] = 1'b1;
    endcase
    tick(1);
    startV = '0;
  endtask

  task automatic waitValid(input int g, input int limit, output int cyc);
    cyc = 0;
    while (!validOf(g) && cyc < limit) begin
      tick(1);
      cyc++;
    end
    if (!validOf(g)) checkOutput($sformatf("inst%0d Valid timeout", g), 0, 1);
  endtask

  task automatic checkResult3(input string tag, input int mn, input int mc, input int best);
    checkOutput({tag, " MinCost"}, int'(inst[0].bus.MinCost), mn);
    checkOutput({tag, " MatchCount"}, int'(inst[0].bus.MatchCount), mc);
    checkOutput({tag, " BestJ"}, int'(inst[0].bus.BestJ), best);
  endtask

  // Scenario sequence
  initial begin
    int c;
    int c3 [3][3] = '{'{5, 1, 9}, '{2, 8, 3}, '{7, 4, 6}};
    rstV = '1;
    startV = '0;
    for (int g = 0; g < 4; g++)
      for (int w = 0; w < 8; w++)
        for (int j = 0; j < 8; j++) begin
          case (g)
            0: costM[g][w][j] = (w < 3 && j < 3) ? c3[w][j] : 0;
            1: costM[g][w][j] = 10;
            default: costM[g][w][j] = int'($urandom_range(0, 127));
          endcase
        end
    tick(3);
    rstV = '0;
    tick(2);
    checkResult3("N3 after reset", 511, 0, 0);

    // Basic 3x3: optimum (1,0,2) = 9
    applyStimulus(0);
    waitValid(0, 40, c);
    checkOutput("N3 run1 Valid cycle", c, 24);
    checkOutput("N3 run1 busy at Valid", int'(busyOf(0)), 1);
    checkResult3("N3 run1", 9, 1, 33);
    tick(1);
    checkOutput("N3 Valid single pulse", int'(validOf(0)), 0);
    checkOutput("N3 busy after Valid", int'(busyOf(0)), 0);

    // Start pulsed again at cycle 5 is ignored
    applyStimulus(0);
    tick(5);
    startV[0] = 1'b1;
    tick(1);
    startV[0] = 1'b0;
    waitValid(0, 40, c);
    checkOutput("N3 ignored start Valid cycle", c + 6, 24);
    checkResult3("N3 ignored start", 9, 1, 33);
    tick(1);
    checkOutput("N3 ignored start no 2nd Valid", int'(validOf(0)), 0);

    // Start held high: back-to-back runs 25 cycles apart
    startV[0] = 1'b1;
    tick(1);
    waitValid(0, 40, c);
    checkOutput("N3 held start 1st Valid", c, 24);
    checkResult3("N3 held 1st", 9, 1, 33);
    tick(1);
    waitValid(0, 40, c);
    checkOutput("N3 held start gap", c + 1, 25);
    startV[0] = 1'b0;
    checkResult3("N3 held 2nd", 9, 1, 33);
    tick(2);

    // Asynchronous reset mid-run, then a clean rerun
    applyStimulus(0);
    tick(10);
    rstV[0] = 1'b1;
    #1;
    checkOutput("N3 reset busy", int'(busyOf(0)), 0);
    checkOutput("N3 reset Valid", int'(validOf(0)), 0);
    checkOutput("N3 reset W", int'(inst[0].bus.W), 0);
    checkOutput("N3 reset J", int'(inst[0].bus.J), 0);
    checkResult3("N3 mid-run reset", 511, 0, 0);
    tick(2);
    rstV[0] = 1'b0;
    tick(1);
    applyStimulus(0);
    waitValid(0, 40, c);
    checkOutput("N3 after reset Valid cycle", c, 24);
    checkResult3("N3 after reset", 9, 1, 33);
    tick(1);

    // Tie-break: (1,2,0) and (2,0,1) both cost 3, first one wins
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 3; j++) costM[0][w][j] = (w == j) ? 5 : 1;
    applyStimulus(0);
    waitValid(0, 40, c);
    checkOutput("N3 tie Valid cycle", c, 24);
    checkResult3("N3 tie", 3, 2, 9);
    tick(1);

    // 4x4 all tens: 24 optima saturate the 4-bit count
    applyStimulus(1);
    waitValid(1, 200, c);
    checkOutput("N4 Valid cycle", c, 120);
    checkOutput("N4 MinCost", int'(inst[1].bus.MinCost), 40);
    checkOutput("N4 MatchCount", int'(inst[1].bus.MatchCount), 15);
    checkOutput("N4 BestJ", int'(inst[1].bus.BestJ), 228);
    tick(1);

    // 6x6 random costs, full range then a narrow range to provoke ties
    applyStimulus(2);
    waitValid(2, 6000, c);
    checkOutput("N6 wide Valid cycle", c, 5040);
    tick(1);
    for (int w = 0; w < 6; w++)
      for (int j = 0; j < 6; j++) costM[2][w][j] = int'($urandom_range(0, 3));
    applyStimulus(2);
    waitValid(2, 6000, c);
    checkOutput("N6 narrow Valid cycle", c, 5040);
    tick(1);

    // 8x8 random costs: opening permutations walked, then reset aborts
    applyStimulus(3);
    tick(2000);
    checkOutput("N8 busy mid-run", int'(busyOf(3)), 1);
    rstV[3] = 1'b1;
    #1;
    checkOutput("N8 reset busy", int'(busyOf(3)), 0);
    checkOutput("N8 reset W", int'(inst[3].bus.W), 0);
    checkOutput("N8 reset MinCost", int'(inst[3].bus.MinCost), 1023);
    tick(2);
    rstV[3] = 1'b0;
    tick(3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
